divider: RTL and testbench



---
 rtl/divider.sv | 196 +++++++++++++++++++
 tb/tb_divider.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// ----------------------------------------------------------------------------
// divider
//   Signed integer stream divider. A dividend arrives on in1 and a divisor on
//   in2 through stb/ack handshakes. The quotient, truncated toward zero, leaves
//   on out1. The core is an iterative restoring divider that produces one
//   quotient bit per clock, so only one operation is in flight at a time.
//   Divide-by-zero yields 0. The most negative value divided by -1 wraps back
//   to the most negative value.
//
// Parameters
//   bits      data width of in1, in2 and out1 (two's complement), 2..32
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous reset, active-high
//   in1       dividend               in1_stb / in1_ack   handshake
//   in2       divisor                in2_stb / in2_ack   handshake
//   out1      quotient               out1_stb / out1_ack handshake
// ----------------------------------------------------------------------------
module divider #(
   parameter int bits = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [bits-1:0] in1,
   input  logic            in1_stb,
   output logic            in1_ack,
   input  logic [bits-1:0] in2,
   input  logic            in2_stb,
   output logic            in2_ack,
   output logic [bits-1:0] out1,
   output logic            out1_stb,
   input  logic            out1_ack
);

   localparam int CNT_W = $clog2(bits) + 1;

   typedef enum logic [2:0] {
      READ_A,
      READ_B,
      PREP,
      DIVIDE,
      SIGN,
      WRITE
   } state_t;

   // Control (reset)
   state_t          state_q,    state_d;
   logic            in1_ack_q,  in1_ack_d;
   logic            in2_ack_q,  in2_ack_d;
   logic            out1_stb_q, out1_stb_d;
   logic [bits-1:0] out1_q,     out1_d;

   // Datapath (no reset)
   logic signed [bits-1:0] a_q,   a_d;
   logic signed [bits-1:0] b_q,   b_d;
   logic                   neg_q, neg_d;
   logic                   dbz_q, dbz_d;
   logic [bits-1:0]        dvd_q, dvd_d;   // dividend magnitude, becomes quotient
   logic [bits:0]          dvs_q, dvs_d;   // divisor magnitude
   logic [bits-1:0]        rem_q, rem_d;   // partial remainder
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic [bits:0]          rem_sh;
   logic                   fits;

   // Magnitude of a two's-complement value, one bit wider so that the
   // magnitude of -2^(bits-1) is exact.
   function automatic logic [bits:0] magnitude(input logic signed [bits-1:0] v);
      logic [bits:0] ext;
      ext = {v[bits-1], v};
      return v[bits-1] ? (~ext + 1'b1) : ext;
   endfunction

   // Restore the sign on the unsigned quotient magnitude; wraps modulo 2^bits.
   function automatic logic [bits-1:0] apply_sign(input logic [bits-1:0] m,
                                                  input logic            neg);
      return neg ? (~m + 1'b1) : m;
   endfunction

   always_comb begin
      state_d    = state_q;
      in1_ack_d  = in1_ack_q;
      in2_ack_d  = in2_ack_q;
      out1_stb_d = out1_stb_q;
      out1_d     = out1_q;
      a_d        = a_q;
      b_d        = b_q;
      neg_d      = neg_q;
      dbz_d      = dbz_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      rem_d      = rem_q;
      cnt_d      = cnt_q;

      // One restoring step: shift {remainder, dividend} left and try a subtract.
      rem_sh = {rem_q, dvd_q[bits-1]};
      fits   = (rem_sh >= dvs_q);

      unique case (state_q)
         READ_A: begin
            if (in1_ack_q && in1_stb) begin
               a_d       = in1;
               in1_ack_d = 1'b0;
               state_d   = READ_B;
            end else begin
               in1_ack_d = 1'b1;
            end
         end

         READ_B: begin
            if (in2_ack_q && in2_stb) begin
               b_d       = in2;
               in2_ack_d = 1'b0;
               state_d   = PREP;
            end else begin
               in2_ack_d = 1'b1;
            end
         end

         PREP: begin
            neg_d = a_q[bits-1] ^ b_q[bits-1];
            dbz_d = (b_q == '0);
            // |a| <= 2^(bits-1) always fits in bits unsigned bits.
            dvd_d = bits'(magnitude(a_q));
            dvs_d = magnitude(b_q);
            rem_d = '0;
            cnt_d = CNT_W'(bits - 1);
            state_d = DIVIDE;
         end

         DIVIDE: begin
            // The remainder stays below the divisor (<= 2^(bits-1)), so the
            // top bit of the shifted value is never needed after the step.
            rem_d = bits'(fits ? (rem_sh - dvs_q) : rem_sh);
            dvd_d = {dvd_q[bits-2:0], fits};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = SIGN;
            end
         end

         SIGN: begin
            // With a zero divisor every trial subtract succeeds, so the
            // quotient must be overridden rather than taken from the core.
            out1_d     = dbz_q ? '0 : apply_sign(dvd_q, neg_q);
            out1_stb_d = 1'b1;
            state_d    = WRITE;
         end

         WRITE: begin
            if (out1_stb_q && out1_ack) begin
               out1_stb_d = 1'b0;
               state_d    = READ_A;
            end
         end

         default: begin
            state_d = READ_A;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= READ_A;
         in1_ack_q  <= 1'b0;
         in2_ack_q  <= 1'b0;
         out1_stb_q <= 1'b0;
         out1_q     <= '0;
      end else begin
         state_q    <= state_d;
         in1_ack_q  <= in1_ack_d;
         in2_ack_q  <= in2_ack_d;
         out1_stb_q <= out1_stb_d;
         out1_q     <= out1_d;
      end
   end

   always_ff @(posedge clk) begin
      a_q   <= a_d;
      b_q   <= b_d;
      neg_q <= neg_d;
      dbz_q <= dbz_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
   end

   assign in1_ack  = in1_ack_q;
   assign in2_ack  = in2_ack_q;
   assign out1     = out1_q;
   assign out1_stb = out1_stb_q;

endmodule

// File: tb/tb_divider.sv
// ----------------------------------------------------------------------------
// tb_divider
//   Directed and randomised bench for divider (bits = 16). Expected quotients
//   come from a C-style truncating division model and are queued when the
//   operands are issued, then popped when the quotient is handed over.
// ----------------------------------------------------------------------------
module tb_divider;

   localparam int W     = 16;
   localparam int LIMIT = 200;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] in1;
   logic         in1_stb;
   logic         in1_ack;
   logic [W-1:0] in2;
   logic         in2_stb;
   logic         in2_ack;
   logic [W-1:0] out1;
   logic         out1_stb;
   logic         out1_ack;

   int           total = 0;
   int           bad   = 0;
   logic [W-1:0] sb[$];

   always #5 clk = ~clk;

   divider #(.bits(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in1      (in1),
      .in1_stb  (in1_stb),
      .in1_ack  (in1_ack),
      .in2      (in2),
      .in2_stb  (in2_stb),
      .in2_ack  (in2_ack),
      .out1     (out1),
      .out1_stb (out1_stb),
      .out1_ack (out1_ack)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // C semantics: truncate toward zero, x/0 = 0, result wraps to W bits.
   function automatic logic [W-1:0] model(input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b);
      int ai;
      int bi;
      int q;
      if (b == 0) return '0;
      ai = a;
      bi = b;
      q  = ai / bi;
      return W'(q);
   endfunction

   // All tasks start and end at 1 time unit after a rising edge.
   task automatic send1(input logic [W-1:0] a, input int gap);
      int n;
      repeat (gap) begin @(posedge clk); #1; end
      in1     = a;
      in1_stb = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in1_ack && n < LIMIT) begin @(negedge clk); n++; end
      if (!in1_ack) chk("in1_ack_timeout", 32'(in1_ack), 32'd1);
      @(posedge clk); #1;
      in1_stb = 1'b0;
      in1     = W'($urandom);
   endtask

   task automatic send2(input logic [W-1:0] b, input int gap);
      int n;
      repeat (gap) begin @(posedge clk); #1; end
      in2     = b;
      in2_stb = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in2_ack && n < LIMIT) begin @(negedge clk); n++; end
      if (!in2_ack) chk("in2_ack_timeout", 32'(in2_ack), 32'd1);
      @(posedge clk); #1;
      in2_stb = 1'b0;
      in2     = W'($urandom);
   endtask

   // Called right after the in2 transfer edge: measures latency, holds off
   // out1_ack for 'hold' cycles checking stability, then takes the word.
   task automatic recv(input string tag, input int hold);
      int           lat;
      logic [W-1:0] got;
      logic [W-1:0] exp;
      lat = 0;
      while (!out1_stb && lat < LIMIT) begin @(posedge clk); #1; lat++; end
      chk({tag, "_lat"}, 32'(lat), 32'(W + 2));
      exp = (sb.size() != 0) ? sb[0] : 'x;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_stb"}, 32'(out1_stb), 32'd1);
         chk({tag, "_hold_out"}, 32'(out1), 32'(exp));
         chk({tag, "_hold_ack1"}, 32'(in1_ack), 32'd0);
         chk({tag, "_hold_ack2"}, 32'(in2_ack), 32'd0);
      end
      out1_ack = 1'b1;
      @(negedge clk);
      got = out1;
      chk({tag, "_stb"}, 32'(out1_stb), 32'd1);
      @(posedge clk); #1;
      out1_ack = 1'b0;
      chk({tag, "_stb_drop"}, 32'(out1_stb), 32'd0);
      chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         exp = sb.pop_front();
         chk(tag, 32'(got), 32'(exp));
      end
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int ga, input int gb, input int hold);
      sb.push_back(model(a, b));
      send1(a, ga);
      send2(b, gb);
      recv(tag, hold);
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
   } vec_t;

   initial begin
      vec_t vecs[$];
      vecs.push_back('{16'd100,  16'd7,    16'h000E});
      vecs.push_back('{-16'sd100, 16'd7,   16'hFFF2});
      vecs.push_back('{16'd100,  -16'sd7,  16'hFFF2});
      vecs.push_back('{-16'sd100, -16'sd7, 16'h000E});
      vecs.push_back('{16'd7,    16'd100,  16'h0000});
      vecs.push_back('{-16'sd7,  16'd100,  16'h0000});
      vecs.push_back('{16'h8000, 16'hFFFF, 16'h8000});
      vecs.push_back('{16'h8000, 16'h0001, 16'h8000});
      vecs.push_back('{16'h7FFF, 16'hFFFF, 16'h8001});
      vecs.push_back('{16'd5,    16'd0,    16'h0000});
      vecs.push_back('{16'd0,    16'd0,    16'h0000});

      rst      = 1'b1;
      in1      = '0;
      in1_stb  = 1'b0;
      in2      = '0;
      in2_stb  = 1'b0;
      out1_ack = 1'b0;

      // Reset state
      repeat (3) begin @(posedge clk); #1; end
      chk("rst_in1_ack", 32'(in1_ack), 32'd0);
      chk("rst_in2_ack", 32'(in2_ack), 32'd0);
      chk("rst_out1_stb", 32'(out1_stb), 32'd0);
      chk("rst_out1", 32'(out1), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("first_in1_ack", 32'(in1_ack), 32'd1);

      // Directed values: model output cross-checked against hand values,
      // then each run through the DUT with zero stalls.
      foreach (vecs[i]) begin
         chk($sformatf("model_%0d", i), 32'(model(vecs[i].a, vecs[i].b)), 32'(vecs[i].q));
         run_op($sformatf("dir_%0d", i), vecs[i].a, vecs[i].b, 0, 0, 0);
      end

      // Backpressure: 1000/10 held for 20 cycles
      run_op("bp", 16'd1000, 16'd10, 0, 0, 20);

      // Reset 5 edges into DIVIDE
      send1(16'd1234, 0);
      send2(16'd5, 0);
      repeat (6) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_in1_ack", 32'(in1_ack), 32'd0);
      chk("mid_rst_in2_ack", 32'(in2_ack), 32'd0);
      chk("mid_rst_out1_stb", 32'(out1_stb), 32'd0);
      chk("mid_rst_out1", 32'(out1), 32'd0);
      run_op("after_rst", 16'd9, 16'd3, 0, 0, 0);

      // Randomised operands and handshake gaps
      for (int k = 0; k < 1000; k++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         int           pick;
         ra   = W'($urandom);
         rb   = W'($urandom);
         pick = $urandom_range(0, 9);
         if (pick == 0) rb = '0;
         if (pick == 1) ra = 16'h8000;
         if (pick == 2) rb = 16'hFFFF;
         if (pick == 3) rb = W'($urandom_range(1, 20));
         run_op("rnd", ra, rb, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3));
      end

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
